// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the keyboard lines, then
// deserialises 11-bit frames into scan-code bytes. Optional macro: PS2_BREAK_FILTER_EN.
module ps2_scan_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt, r_clk_filt_q;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fall;
  logic          w_dat;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_parity, w_parity_nxt;
  logic [TW-1:0] r_to_cnt, w_to_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_en_nxt, w_pe_nxt, w_fe_nxt;
`ifdef PS2_BREAK_FILTER_EN
  logic          r_suppress, w_sup_nxt;
`endif

  // Two-flop synchronisers plus a run-length filter on the clock line
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_clk_filt   <= 1'b1;
      r_clk_filt_q <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_s1     <= PS2_CLK;
      r_clk_s2     <= r_clk_s1;
      r_dat_s1     <= PS2_DAT;
      r_dat_s2     <= r_dat_s1;
      r_clk_filt_q <= r_clk_filt;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_fall = r_clk_filt_q & ~r_clk_filt;
  assign w_dat  = r_dat_s2;

  // Frame FSM state and datapath registers
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state          <= IDLE;
      r_bit_cnt        <= '0;
      r_shift          <= '0;
      r_parity         <= 1'b0;
      r_to_cnt         <= '0;
      received_data    <= 8'h00;
      received_data_en <= 1'b0;
      parity_err       <= 1'b0;
      frame_err        <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      r_suppress       <= 1'b0;
`endif
    end else begin
      r_state          <= w_state_nxt;
      r_bit_cnt        <= w_bit_nxt;
      r_shift          <= w_shift_nxt;
      r_parity         <= w_parity_nxt;
      r_to_cnt         <= w_to_nxt;
      received_data    <= w_data_nxt;
      received_data_en <= w_en_nxt;
      parity_err       <= w_pe_nxt;
      frame_err        <= w_fe_nxt;
`ifdef PS2_BREAK_FILTER_EN
      r_suppress       <= w_sup_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bit_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_to_nxt     = '0;
    w_data_nxt   = received_data;
    w_en_nxt     = 1'b0;
    w_pe_nxt     = 1'b0;
    w_fe_nxt     = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    w_sup_nxt    = r_suppress;
`endif

    case (r_state)
      IDLE: begin
        if (w_fall && !w_dat) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_fall) begin
          w_shift_nxt = {w_dat, r_shift[7:1]};
          w_bit_nxt   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (w_fall) begin
          w_parity_nxt = w_dat;
          w_state_nxt  = STOP;
        end
      end
      STOP: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          if (!w_dat) begin
            w_fe_nxt = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
            w_sup_nxt = 1'b0;
`endif
          end else if (!(^{r_shift, r_parity})) begin
            w_pe_nxt = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
            w_sup_nxt = 1'b0;
`endif
          end else begin
`ifdef PS2_BREAK_FILTER_EN
            // F0 arms suppression of itself and the following released key code
            if (r_shift == 8'hF0) begin
              w_sup_nxt = 1'b1;
            end else if (r_shift == 8'hE0) begin
              w_data_nxt = r_shift;
              w_en_nxt   = 1'b1;
            end else if (r_suppress) begin
              w_sup_nxt = 1'b0;
            end else begin
              w_data_nxt = r_shift;
              w_en_nxt   = 1'b1;
            end
`else
            w_data_nxt = r_shift;
            w_en_nxt   = 1'b1;
`endif
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Inter-edge watchdog; a real edge always wins over an expiring count
    if (r_state != IDLE) begin
      if (w_fall) begin
        w_to_nxt = '0;
      end else if (r_to_cnt == TO_LAST) begin
        w_state_nxt = IDLE;
        w_fe_nxt    = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
        w_sup_nxt   = 1'b0;
`endif
      end else begin
        w_to_nxt = r_to_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Randomised bench for ps2_scan_receiver: an expected-event queue built from frame
// contents is checked against the DUT strobes every cycle.
module tb_ps2_scan_receiver;

  localparam int TO   = 2000;
  localparam int HALF = 30;
  localparam int H2   = HALF / 2;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       parity_err;
  logic       frame_err;

  ps2_scan_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50        (CLOCK_50),
    .Resetn          (Resetn),
    .PS2_CLK         (PS2_CLK),
    .PS2_DAT         (PS2_DAT),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .parity_err      (parity_err),
    .frame_err       (frame_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         kind;   // 1 = data, 2 = parity error, 3 = frame error
    logic [7:0] data;
    int         lo;
    int         hi;
  } ev_t;

  ev_t        q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] exp_data;
  bit         sup;
  bit         prev_any = 1'b0;
  int         ns;
  int         kind_act;
  ev_t        e;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_ev(input int k, input logic [7:0] d, input int t);
    ev_t x;
    x.kind = k; x.data = d; x.lo = t; x.hi = t;
    if (k == 3 && d == 8'hFF) begin
      x.data = 8'h00; x.lo = t + TO; x.hi = t + TO + 20;
    end else begin
      x.lo = t + 8; x.hi = t + 16;
    end
    q.push_back(x);
  endtask

  // Reference outcome of a complete frame, from its contents alone
  task automatic model_frame(input logic [7:0] b, input bit par, input bit stop, input int t);
    if (!stop) begin
      push_ev(3, 8'h00, t); sup = 1'b0;
    end else if ((^b ^ par) != 1'b1) begin
      push_ev(2, 8'h00, t); sup = 1'b0;
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (b == 8'hF0) sup = 1'b1;
      else if (b == 8'hE0) push_ev(1, b, t);
      else if (sup) sup = 1'b0;
      else push_ev(1, b, t);
`else
      push_ev(1, b, t);
`endif
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par, input bit stop);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      PS2_DAT = bits[i];
      wait_cyc(H2);
      PS2_CLK = 1'b0;
      if (i == 10) model_frame(b, par, stop, cyc);
      wait_cyc(HALF);
      PS2_CLK = 1'b1;
      wait_cyc(H2);
    end
    PS2_DAT = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, output int t_last);
    t_last = cyc;
    for (int i = 0; i < n; i++) begin
      PS2_DAT = bits[i];
      wait_cyc(H2);
      PS2_CLK = 1'b0;
      t_last = cyc;
      wait_cyc(HALF);
      PS2_CLK = 1'b1;
      wait_cyc(H2);
    end
    PS2_DAT = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      wait_cyc(1);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(received_data), 32'h00);
    chk({tag, "_en"}, 32'(received_data_en), 32'd0);
    chk({tag, "_perr"}, 32'(parity_err), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  // Per-cycle compare of strobes and held data against the expected-event queue
  always @(negedge CLOCK_50) begin
    ns = int'(received_data_en) + int'(parity_err) + int'(frame_err);
    if (ns != 0) begin
      chk("strobes_exclusive", 32'(ns), 32'd1);
      chk("no_back_to_back", 32'(prev_any), 32'd0);
      kind_act = received_data_en ? 1 : (parity_err ? 2 : 3);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got kind %0d data %0h, expected none (cycle %0d)",
                 kind_act, received_data, cyc);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", 32'(kind_act), 32'(e.kind));
        if (e.kind == 1) begin
          chk("strobe_data", 32'(received_data), 32'(e.data));
          exp_data = e.data;
        end
        n_cmp++;
        if (cyc < e.lo || cyc > e.hi) begin
          n_bad++;
          $display("FAIL strobe_latency: got cycle %0d expected %0d..%0d", cyc, e.lo, e.hi);
        end
      end
    end
    prev_any = (ns != 0);
    chk("held_data", 32'(received_data), 32'(exp_data));
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    logic [7:0]  b;
    bit          par, stop;
    Resetn   = 1'b0;
    PS2_CLK  = 1'b1;
    PS2_DAT  = 1'b1;
    exp_data = 8'h00;
    sup      = 1'b0;
    wait_cyc(5);
    chk_reset_outputs("reset");
    Resetn = 1'b1;
    wait_cyc(20);

    send_frame(8'h23, 1'b0, 1'b1);
    drain();
    chk("frame23", 32'(received_data), 32'h23);

    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1);
    drain();
    chk("b2b_hold29", 32'(received_data), 32'h29);

    send_frame(8'h23, 1'b1, 1'b1);
    drain();
    chk("parity_keeps29", 32'(received_data), 32'h29);

    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h23, 1'b0, 1'b1);
    drain();
`ifdef PS2_BREAK_FILTER_EN
    chk("break_suppressed", 32'(received_data), 32'h29);
`else
    chk("break_emitted", 32'(received_data), 32'h23);
`endif

    // Partial frame: start + 4 data bits, then the clock idles high
    send_bits(11'b000_0000_0110, 5, t);
    push_ev(3, 8'hFF, t);
    sup = 1'b0;
    wait_cyc(TO + 100);
    drain();
    send_frame(8'h29, 1'b0, 1'b1);
    drain();
    chk("after_timeout29", 32'(received_data), 32'h29);

    // Short low glitch in IDLE must not be seen as an edge
    PS2_CLK = 1'b0;
    wait_cyc(4);
    PS2_CLK = 1'b1;
    wait_cyc(60);
    chk("glitch_ignored", 32'(q.size()) + 32'(received_data), 32'h29);

    // Reset in the middle of a frame
    send_bits(11'b000_0000_1100, 4, t);
    Resetn   = 1'b0;
    exp_data = 8'h00;
    sup      = 1'b0;
    wait_cyc(3);
    chk_reset_outputs("midreset");
    wait_cyc(5);
    Resetn = 1'b1;
    wait_cyc(20);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain();
    chk("after_reset1C", 32'(received_data), 32'h1C);

    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
`ifdef PS2_BREAK_FILTER_EN
      if ($urandom_range(0, 3) == 0) b = 8'hF0;
      else if ($urandom_range(0, 7) == 0) b = 8'hE0;
`endif
      par  = ~(^b);
      if ($urandom_range(0, 7) == 0) par = ~par;
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, par, stop);
      wait_cyc($urandom_range(10, 60));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
